// File: rtl/spectrum_pkg.sv
// spectrum_pkg: shared sizes, FSM states and abs helper for the spectrum bin buffer
package spectrum_pkg;
  localparam int N_POINTS = 128;
  localparam int N_BINS = 64;
  localparam int DATA_W = 16;
  localparam int MAG_W = 16;
  typedef enum logic {WAIT_SYNC, COLLECT} state_t;
  function automatic logic [DATA_W-1:0] abs_sat(input logic signed [DATA_W-1:0] x);
    return (x == {1'b1, {(DATA_W-1){1'b0}}}) ? {1'b0, {(DATA_W-1){1'b1}}} : (x[DATA_W-1] ? -x : x);
  endfunction
endpackage

// File: rtl/spectrum_mag_approx.sv
// spectrum_mag_approx: 3-stage max + min/2 magnitude estimate with valid and bin tag
module spectrum_mag_approx
  import spectrum_pkg::*;
(
  input  logic                     clock_50,
  input  logic                     reset,
  input  logic                     valid,
  input  logic [5:0]               tag,
  input  logic signed [DATA_W-1:0] re,
  input  logic signed [DATA_W-1:0] im,
  output logic                     mag_valid,
  output logic [5:0]               mag_tag,
  output logic [MAG_W-1:0]         mag
);
  logic v1, v2;
  logic [5:0] t1, t2;
  logic [DATA_W-1:0] a_re, a_im, mx, mn;
  logic [MAG_W:0] sum;
  assign sum = (MAG_W+1)'(mx) + (MAG_W+1)'(mn >> 1);
  always_ff @(posedge clock_50) begin
    if (reset) {v1, v2, mag_valid} <= '0;
    else {v1, v2, mag_valid} <= {valid, v1, v2};
    {t1, t2, mag_tag} <= {tag, t1, t2};
    a_re <= abs_sat(re);
    a_im <= abs_sat(im);
    mx <= (a_re > a_im) ? a_re : a_im;
    mn <= (a_re > a_im) ? a_im : a_re;
    mag <= sum[MAG_W] ? '1 : sum[MAG_W-1:0];
  end
endmodule

// File: rtl/spectrum_bin_buffer.sv
// spectrum_bin_buffer: frames FFT samples, stores positive-bin magnitudes in a ping-pong RAM
module spectrum_bin_buffer
  import spectrum_pkg::*;
(
  input  logic                     clock_50,
  input  logic                     reset,
  input  logic                     sample_valid,
  input  logic                     frame_start,
  input  logic signed [DATA_W-1:0] data_in_real,
  input  logic signed [DATA_W-1:0] data_in_imag,
  input  logic [5:0]               read_addr,
  output logic [MAG_W-1:0]         read_data,
  output logic                     frame_ready,
  output logic [7:0]               frame_count,
  output logic [7:0]               abort_count
);
  state_t state, state_d;
  logic [6:0] index, idx;
  logic accept, abort, complete, read_bank, have_frame, mag_valid;
  logic [5:0] mag_tag;
  logic [MAG_W-1:0] mag;
  logic [MAG_W-1:0] ram [2*N_BINS];
  always_comb begin
    idx = (state == WAIT_SYNC || frame_start) ? '0 : index;
    accept = sample_valid && (state == COLLECT || frame_start);
    abort = sample_valid && frame_start && state == COLLECT && index != '0;
    complete = accept && idx == 7'(N_POINTS-1);
    state_d = accept ? COLLECT : state;
  end
  always_ff @(posedge clock_50) state <= reset ? WAIT_SYNC : state_d;
  always_ff @(posedge clock_50) begin
    if (reset) begin
      index <= '0;
      frame_ready <= 1'b0;
      frame_count <= '0;
      abort_count <= '0;
      read_bank <= 1'b0;
      have_frame <= 1'b0;
    end else begin
      if (accept) index <= idx + 7'd1;
      frame_ready <= complete;
      if (complete) begin
        read_bank <= ~read_bank;
        have_frame <= 1'b1;
        frame_count <= frame_count + 8'd1;
      end
      if (abort) abort_count <= abort_count + 8'(abort_count != 8'hff);
    end
  end
  spectrum_mag_approx u_mag (
    .clock_50 (clock_50),
    .reset    (reset),
    .valid    (accept && !idx[6]),
    .tag      (idx[5:0]),
    .re       (data_in_real),
    .im       (data_in_imag),
    .mag_valid(mag_valid),
    .mag_tag  (mag_tag),
    .mag      (mag)
  );
  // a swap is always at least 64 samples after the last bin write, so ~read_bank at write time is the frame's bank
  always_ff @(posedge clock_50) if (mag_valid) ram[{~read_bank, mag_tag}] <= mag;
  always_ff @(posedge clock_50) begin
    if (reset) read_data <= '0;
    else read_data <= have_frame ? ram[{read_bank, read_addr}] : '0;
  end
endmodule

// File: tb/tb_spectrum_bin_buffer.sv
// tb_spectrum_bin_buffer: directed checks of framing, magnitude, ping-pong swap, abort and reset
module tb_spectrum_bin_buffer;
  logic clock_50 = 1'b0;
  logic reset = 1'b1;
  logic sample_valid = 1'b0;
  logic frame_start = 1'b0;
  logic signed [15:0] data_in_real = '0;
  logic signed [15:0] data_in_imag = '0;
  logic [5:0] read_addr = '0;
  logic [15:0] read_data;
  logic frame_ready;
  logic [7:0] frame_count, abort_count;
  logic signed [15:0] fre [128];
  logic signed [15:0] fim [128];
  int errors = 0;
  int checks = 0;
  int fr_pulses = 0;

  spectrum_bin_buffer dut (
    .clock_50    (clock_50),
    .reset       (reset),
    .sample_valid(sample_valid),
    .frame_start (frame_start),
    .data_in_real(data_in_real),
    .data_in_imag(data_in_imag),
    .read_addr   (read_addr),
    .read_data   (read_data),
    .frame_ready (frame_ready),
    .frame_count (frame_count),
    .abort_count (abort_count)
  );

  always #5 clock_50 = ~clock_50;
  always @(negedge clock_50) if (frame_ready) fr_pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock_50);
      #1;
    end
  endtask

  task automatic send(input logic fs, input logic signed [15:0] r, input logic signed [15:0] i);
    sample_valid = 1'b1;
    frame_start = fs;
    data_in_real = r;
    data_in_imag = i;
    @(posedge clock_50);
    #1;
    sample_valid = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic send_range(input int first, input int last, input logic fs0, input int gap_max);
    for (int k = first; k <= last; k++) begin
      send(fs0 && k == 0, fre[k], fim[k]);
      if (gap_max > 0 && k < last) idle(int'($urandom_range(0, gap_max)));
    end
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] exp, input string tag);
    read_addr = a;
    @(posedge clock_50);
    #1;
    chk(tag, read_data, exp);
  endtask

  initial begin
    idle(3);
    chk("rst_read_data", read_data, 0);
    chk("rst_frame_ready", frame_ready, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_abort_count", abort_count, 0);
    reset = 1'b0;
    // samples before any frame_start are ignored
    for (int k = 0; k < 5; k++) send(1'b0, 16'sd1234, 16'sd0);
    idle(4);
    chk("presync_pulses", fr_pulses, 0);
    chk("presync_count", frame_count, 0);
    // frame A: ramp plus magnitude corner cases
    for (int k = 0; k < 128; k++) begin
      fre[k] = 16'(k * 100);
      fim[k] = '0;
    end
    fre[5] = 16'sd3000;   fim[5] = -16'sd4000;
    fre[6] = -16'sd32768; fim[6] = -16'sd32768;
    fre[7] = 16'sd32767;  fim[7] = 16'sd32767;
    send_range(0, 126, 1'b1, 0);
    rd(6'd10, 0, "pre_first_frame_read");
    send(1'b0, fre[127], fim[127]);
    chk("a_frame_ready", frame_ready, 1);
    chk("a_frame_count", frame_count, 1);
    rd(6'd10, 1000, "a_bin10");
    chk("a_ready_pulse_end", frame_ready, 0);
    rd(6'd5, 5500, "a_bin5");
    rd(6'd6, 49150, "a_bin6_minneg");
    rd(6'd7, 49150, "a_bin7_maxpos");
    rd(6'd0, 0, "a_bin0");
    rd(6'd63, 6300, "a_bin63");
    // frame B aborted at index 50, then restarted
    for (int k = 0; k < 128; k++) begin
      fre[k] = 16'sd7777;
      fim[k] = '0;
    end
    send_range(0, 49, 1'b1, 0);
    for (int k = 0; k < 128; k++) fre[k] = 16'(k * 10);
    send(1'b1, fre[0], fim[0]);
    chk("abort_count", abort_count, 1);
    idle(4);
    chk("abort_no_pulse", fr_pulses, 1);
    rd(6'd10, 1000, "abort_bank_held");
    send_range(1, 127, 1'b0, 0);
    chk("b_frame_ready", frame_ready, 1);
    chk("b_frame_count", frame_count, 2);
    rd(6'd10, 100, "b_bin10");
    rd(6'd40, 400, "b_bin40");
    chk("b_abort_count", abort_count, 1);
    // frames C and D back to back with random gaps; D starts without frame_start
    for (int k = 0; k < 128; k++) fre[k] = 16'(k);
    fre[3] = 16'sd111;
    send_range(0, 127, 1'b1, 2);
    chk("c_frame_count", frame_count, 3);
    rd(6'd3, 111, "c_bin3");
    for (int k = 0; k < 128; k++) fre[k] = 16'(k * 3);
    fre[3] = 16'sd222;
    send_range(0, 126, 1'b0, 2);
    rd(6'd3, 111, "d_collect_bin3");
    send(1'b0, fre[127], fim[127]);
    chk("d_frame_ready", frame_ready, 1);
    rd(6'd3, 222, "d_swap_cycle_bin3");
    chk("d_frame_count", frame_count, 4);
    rd(6'd20, 60, "d_bin20");
    // reset in the middle of frame E
    for (int k = 0; k < 128; k++) fre[k] = 16'sd5;
    send_range(0, 89, 1'b1, 0);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    chk("mid_rst_read_data", read_data, 0);
    chk("mid_rst_frame_ready", frame_ready, 0);
    chk("mid_rst_frame_count", frame_count, 0);
    chk("mid_rst_abort_count", abort_count, 0);
    rd(6'd20, 0, "mid_rst_no_frame");
    for (int k = 0; k < 128; k++) fre[k] = 16'(k * 2);
    send_range(0, 127, 1'b1, 1);
    chk("f_frame_ready", frame_ready, 1);
    chk("f_frame_count", frame_count, 1);
    chk("f_abort_count", abort_count, 0);
    rd(6'd20, 40, "f_bin20");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
